// File: rtl/dma_arbiter_if.sv
// dma_arbiter_if: requester request/response lines plus the shared DMA engine channel
interface dma_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 381,
    parameter int ADDR_W = 32
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_write;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        rsp_ack;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic                   busy;
    logic                   dma_rx_start;
    logic                   dma_tx_start;
    logic [ADDR_W-1:0]      dma_rx_address;
    logic [ADDR_W-1:0]      dma_tx_address;
    logic [DATA_W-1:0]      dma_tx_data;
    logic [DATA_W-1:0]      dma_rx_data;
    logic                   dma_done;
    logic                   dma_idle;
    logic                   dma_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output dma_rx_data, dma_done, dma_idle, dma_error,
        input  rsp_ack, rsp_rdata, rsp_err, busy,
        input  dma_rx_start, dma_tx_start, dma_rx_address, dma_tx_address, dma_tx_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  dma_rx_data, dma_done, dma_idle, dma_error,
        output rsp_ack, rsp_rdata, rsp_err, busy,
        output dma_rx_start, dma_tx_start, dma_rx_address, dma_tx_address, dma_tx_data
    );
endinterface

// File: rtl/dma_arbiter.sv
// dma_arbiter: round-robin sequencer sharing one DMA engine; DMA_ARB_TIMEOUT_EN adds a WAIT watchdog
module dma_arbiter #(
    parameter int NREQ           = 4,
    parameter int DATA_W         = 381,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic         clk,
    input logic         rst,
    dma_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_n;
    logic [IW-1:0]     ptr, gnt, win;
    logic              found, gnt_write, err_q, expired;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;

    // scan upward from the slot after the last grant, wrapping around
    always_comb begin
        win   = ptr;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && bus.req_valid[IW'((int'(ptr) + i) % NREQ)]) begin
                win   = IW'((int'(ptr) + i) % NREQ);
                found = 1'b1;
            end
        end
    end

`ifdef DMA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign expired = cnt == CW'(TIMEOUT_CYCLES);
    always_ff @(posedge clk) begin
        if (rst || state != WAIT) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign expired        = 1'b0;
    assign unused_timeout = TIMEOUT_CYCLES != 0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = found ? ISSUE : IDLE;
            ISSUE:   state_n = bus.dma_idle ? ISSUE : WAIT;
            WAIT:    state_n = (bus.dma_done || expired) ? RESP : WAIT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IW'(NREQ - 1);
            gnt       <= '0;
            gnt_write <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && found) begin
                gnt       <= win;
                gnt_write <= bus.req_write[win];
                addr_q    <= bus.req_addr[win*ADDR_W +: ADDR_W];
                wdata_q   <= bus.req_wdata[win*DATA_W +: DATA_W];
            end
            // a done coinciding with the watchdog limit wins over the timeout
            if (state == WAIT && bus.dma_done) begin
                err_q <= bus.dma_error;
                if (!gnt_write) rdata_q <= bus.dma_rx_data;
            end else if (state == WAIT && expired) begin
                err_q <= 1'b1;
            end
            if (state == RESP) ptr <= gnt;
        end
    end

    assign bus.busy           = state != IDLE;
    assign bus.dma_rx_start   = state == ISSUE && !gnt_write;
    assign bus.dma_tx_start   = state == ISSUE && gnt_write;
    assign bus.dma_rx_address = addr_q;
    assign bus.dma_tx_address = addr_q;
    assign bus.dma_tx_data    = wdata_q;
    assign bus.rsp_ack        = (state == RESP) ? NREQ'(1) << gnt : '0;
    assign bus.rsp_err        = state == RESP && err_q;
    assign bus.rsp_rdata      = rdata_q;
endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: directed scoreboard bench for dma_arbiter; covers DMA_ARB_TIMEOUT_EN when defined
module tb_dma_arbiter;
    localparam int NREQ = 4, DATA_W = 381, ADDR_W = 32, TO = 16;

    typedef struct {
        logic [NREQ-1:0]   ack;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              idle_force = 1'b0;
    logic [DATA_W-1:0] model_rdata = '0;
    logic [DATA_W-1:0] wd2, dj;
    rsp_t              sb[$];
    rsp_t              e;
    int                tests = 0, fails = 0, cyc = 0, t0 = 0, n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dma_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dma_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // DMA leaves idle as soon as it sees a start unless the bench holds it idle
    assign bus.dma_idle = idle_force | ~(bus.dma_rx_start | bus.dma_tx_start);

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        bus.req_valid[i] = 1'b1;
        bus.req_write[i] = w;
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_wdata[i*DATA_W +: DATA_W] = wd;
    endtask

    task automatic expect_rsp(input int i, input logic w, input logic [DATA_W-1:0] d, input logic er);
        if (!w) model_rdata = d;
        sb.push_back('{ack: NREQ'(1) << i, rdata: model_rdata, err: er});
    endtask

    task automatic wait_start(output int cnt);
        cnt = 0;
        while (!(bus.dma_rx_start || bus.dma_tx_start) && cnt < 50) begin
            tick();
            cnt++;
        end
        tests++;
        assert (cnt < 50) else begin
            fails++;
            $error("FAIL start_wait: got no start expected start within 50 cycles");
        end
    endtask

    task automatic serve(input int k, input logic [DATA_W-1:0] d, input logic er, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd, input logic scramble);
        int c;
        wait_start(c);
        if (c >= 50) return;
        check("rx_start", DATA_W'(bus.dma_rx_start), DATA_W'(!w));
        check("tx_start", DATA_W'(bus.dma_tx_start), DATA_W'(w));
        check("issue_addr", DATA_W'(w ? bus.dma_tx_address : bus.dma_rx_address), DATA_W'(a));
        if (w) check("issue_tx_data", bus.dma_tx_data, wd);
        if (scramble) begin
            bus.req_addr  = ~bus.req_addr;
            bus.req_wdata = ~bus.req_wdata;
            bus.req_write = ~bus.req_write;
        end
        tick(k + 1);
        bus.dma_done    = 1'b1;
        bus.dma_error   = er;
        bus.dma_rx_data = d;
        tick();
        bus.dma_done  = 1'b0;
        bus.dma_error = 1'b0;
        check("resp_addr", DATA_W'(w ? bus.dma_tx_address : bus.dma_rx_address), DATA_W'(a));
        if (w) check("resp_tx_data", bus.dma_tx_data, wd);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rsp_ack != '0) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_ack: got %b expected no ack", bus.rsp_ack);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_ack", DATA_W'(bus.rsp_ack), DATA_W'(e.ack));
                check("sb_rdata", bus.rsp_rdata, e.rdata);
                check("sb_err", DATA_W'(bus.rsp_err), DATA_W'(e.err));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        bus.req_valid   = '0;
        bus.req_write   = '0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.dma_done    = 1'b0;
        bus.dma_error   = 1'b0;
        bus.dma_rx_data = '0;
        tick(2);
        check("rst_busy", DATA_W'(bus.busy), '0);
        check("rst_ack", DATA_W'(bus.rsp_ack), '0);
        check("rst_err", DATA_W'(bus.rsp_err), '0);
        check("rst_rdata", bus.rsp_rdata, '0);
        check("rst_starts", DATA_W'({bus.dma_rx_start, bus.dma_tx_start}), '0);
        check("rst_addrs", DATA_W'({bus.dma_rx_address, bus.dma_tx_address}), '0);
        check("rst_tx_data", bus.dma_tx_data, '0);
        rst = 1'b0;
        tick();

        // single rx by requester 2, done 5 cycles after WAIT entry
        set_req(2, 1'b0, 32'h1000_0000, '0);
        t0 = cyc;
        expect_rsp(2, 1'b0, DATA_W'(381'h1ABC), 1'b0);
        serve(5, DATA_W'(381'h1ABC), 1'b0, 1'b0, 32'h1000_0000, '0, 1'b0);
        check("t1_ack", DATA_W'(bus.rsp_ack), DATA_W'(4'b0100));
        check("t1_latency", DATA_W'(cyc - t0), DATA_W'(8));
        bus.req_valid = '0;
        tick();

        // tx by requester 1 held in ISSUE; stray done and a withdrawn request meanwhile
        wd2 = {32'hDEADBEEF, 349'h1234_5678};
        set_req(1, 1'b1, 32'h2000_0040, wd2);
        idle_force = 1'b1;
        tick(2);
        bus.req_valid[0] = 1'b1;
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        tick();
        check("issue_hold_tx", DATA_W'(bus.dma_tx_start), DATA_W'(1));
        check("issue_hold_rx", DATA_W'(bus.dma_rx_start), '0);
        bus.req_valid[0] = 1'b0;
        idle_force = 1'b0;
        expect_rsp(1, 1'b1, '0, 1'b0);
        serve(3, {DATA_W{1'b1}}, 1'b0, 1'b1, 32'h2000_0040, wd2, 1'b1);
        bus.req_valid = '0;
        tick(3);
        check("withdrawn_idle", DATA_W'(bus.busy), '0);

        // error on requester 3, then a clean transfer by requester 0
        set_req(3, 1'b0, 32'h3000_0000, '0);
        expect_rsp(3, 1'b0, DATA_W'(381'h3333), 1'b1);
        serve(2, DATA_W'(381'h3333), 1'b1, 1'b0, 32'h3000_0000, '0, 1'b0);
        bus.req_valid = '0;
        tick();
        set_req(0, 1'b0, 32'h3000_0100, '0);
        expect_rsp(0, 1'b0, DATA_W'(381'h4444), 1'b0);
        serve(1, DATA_W'(381'h4444), 1'b0, 1'b0, 32'h3000_0100, '0, 1'b0);
        bus.req_valid = '0;
        tick();

        // reset during WAIT, then a stray done
        set_req(2, 1'b0, 32'h4000_0000, '0);
        wait_start(n);
        tick(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
        check("midrst_busy", DATA_W'(bus.busy), '0);
        bus.dma_done    = 1'b1;
        bus.dma_rx_data = {DATA_W{1'b1}};
        tick();
        bus.dma_done = 1'b0;
        tick(3);
        check("stray_busy", DATA_W'(bus.busy), '0);
        check("stray_rdata", bus.rsp_rdata, '0);
        model_rdata = '0;

        // all requesters continuously valid: grants rotate from requester 0
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 32'h5000_0000 + ADDR_W'(i), '0);
        for (int j = 0; j < 8; j++) begin
            dj = DATA_W'(64'hA5A5_0000_0000) + DATA_W'(j);
            expect_rsp(j % NREQ, 1'b0, dj, 1'b0);
            serve(j % 3, dj, 1'b0, 1'b0, 32'h5000_0000 + ADDR_W'(j % NREQ), '0, 1'b0);
        end
        bus.req_valid = '0;
        tick(2);

`ifdef DMA_ARB_TIMEOUT_EN
        // no done: watchdog ends WAIT after TO cycles
        set_req(1, 1'b0, 32'h6000_0000, '0);
        expect_rsp(1, 1'b1, '0, 1'b1);
        wait_start(n);
        t0 = cyc + 1;
        n = 0;
        while (bus.rsp_ack == '0 && n < 40) begin
            tick();
            n++;
        end
        check("timeout_seen", DATA_W'(n < 40), DATA_W'(1));
        check("timeout_latency", DATA_W'(cyc - t0), DATA_W'(TO + 1));
        bus.req_valid = '0;
        tick(2);
`endif

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
